// File: rtl/codepoint_mark_pkg.sv
// Shared types and constants for the codepoint <-> mark translator.
package codepoint_mark_pkg;

    localparam int CPM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    localparam logic MODE_MARK_FOR_CP = 1'b0;
    localparam logic MODE_CP_FOR_MARK = 1'b1;

    localparam logic [CPM_DATA_W-1:0] NO_MARK = '0;

    typedef struct packed {
        logic                  valid;
        logic [CPM_DATA_W-1:0] lo;
        logic [CPM_DATA_W-1:0] hi;
        logic [CPM_DATA_W-1:0] base;
    } range_entry_t;

endpackage

// File: rtl/codepoint_range_match.sv
// Tests one table entry against the key in either direction.
module codepoint_range_match
    import codepoint_mark_pkg::*;
#(
    parameter int DATA_W = CPM_DATA_W
) (
    input  range_entry_t      entry,
    input  logic [DATA_W-1:0] key,
    input  logic              mode,
    output logic              hit,
    output logic              below,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] w_span;

    assign w_span = entry.hi - entry.lo;

    always_comb begin
        hit    = 1'b0;
        below  = 1'b0;
        result = NO_MARK;
        case (mode)
            MODE_MARK_FOR_CP: begin
                if (key < entry.lo) begin
                    below = 1'b1;
                end else if (key <= entry.hi) begin
                    hit    = 1'b1;
                    result = entry.base + (key - entry.lo);
                end
            end
            MODE_CP_FOR_MARK: begin
                // Mark 0 never maps to a codepoint, whatever the table says.
                if ((key == '0) || (key < entry.base)) begin
                    below = 1'b1;
                end else if (key <= entry.base + w_span) begin
                    hit    = 1'b1;
                    result = entry.lo + (key - entry.base);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/codepoint_mark_map.sv
// Runtime-loadable codepoint <-> mark translator: linear scan of a sorted
// range table, one entry per cycle, behind a call/return handshake.
module codepoint_mark_map
    import codepoint_mark_pkg::*;
#(
    parameter int DATA_W     = CPM_DATA_W,
    parameter int NUM_RANGES = 16,
    parameter int IDX_W      = $clog2(NUM_RANGES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] c,
    output logic              busy,
    output logic              done,
    input  logic              stall,
    output logic [DATA_W-1:0] returndata,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_lo,
    input  logic [DATA_W-1:0] cfg_hi,
    input  logic [DATA_W-1:0] cfg_base,
    output logic              cfg_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RANGES - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_next;
    logic [DATA_W-1:0] r_key;
    logic              r_mode;
    logic [DATA_W-1:0] r_result;
    logic              w_load_result;
    logic [DATA_W-1:0] w_result_next;
    logic              r_cfg_err;

    range_entry_t      r_table [NUM_RANGES];
    range_entry_t      w_entry;
    logic              w_hit;
    logic              w_below;
    logic [DATA_W-1:0] w_match_result;
    logic              w_addr_ok;
    logic              w_wr_en;

    assign w_addr_ok = ({1'b0, cfg_addr} < (IDX_W+1)'(NUM_RANGES));
    assign w_wr_en   = cfg_we && (r_state == IDLE) && w_addr_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RANGES; gi++) begin : g_entry
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_table[gi] <= '0;
                end else if (w_wr_en && (cfg_addr == IDX_W'(gi))) begin
                    r_table[gi] <= '{valid: cfg_valid, lo: cfg_lo, hi: cfg_hi, base: cfg_base};
                end
            end
        end
    endgenerate

    assign w_entry = r_table[r_idx];

    codepoint_range_match #(
        .DATA_W (DATA_W)
    ) u_match (
        .entry  (w_entry),
        .key    (r_key),
        .mode   (r_mode),
        .hit    (w_hit),
        .below  (w_below),
        .result (w_match_result)
    );

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_load_result = 1'b0;
        w_result_next = NO_MARK;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SCAN;
                    w_idx_next   = '0;
                end
            end
            SCAN: begin
                // Sorted table: an invalid entry or a key below this range ends the search.
                if (!w_entry.valid || w_below) begin
                    w_state_next  = RESP;
                    w_load_result = 1'b1;
                end else if (w_hit) begin
                    w_state_next  = RESP;
                    w_load_result = 1'b1;
                    w_result_next = w_match_result;
                end else if (r_idx == LAST_IDX) begin
                    w_state_next  = RESP;
                    w_load_result = 1'b1;
                end else begin
                    w_idx_next = r_idx + IDX_W'(1);
                end
            end
            RESP: begin
                if (!stall) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_key     <= '0;
            r_mode    <= MODE_MARK_FOR_CP;
            r_result  <= NO_MARK;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_cfg_err <= cfg_we && !((r_state == IDLE) && w_addr_ok);
            if ((r_state == IDLE) && start) begin
                r_key  <= c;
                r_mode <= mode;
            end
            if (w_load_result) begin
                r_result <= w_result_next;
            end
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == RESP);
    assign returndata = r_result;
    assign cfg_err    = r_cfg_err;

endmodule
